// File: rtl/cn_pkg.sv
// Shared constants and helpers for the compressed check-node message format.
// The field offsets are used by both the compressor and the recover units.
package cn_pkg;

   localparam int Wc        = 32;
   localparam int Wcbits    = 5;
   localparam int W         = 10;
   localparam int Wabs      = W - 1;
   localparam int ECOMPSIZE = 2 * Wabs + Wcbits + Wc;

   // Packing: {min1, min2, idx, sign}, with sign in the low bits.
   localparam int SIGN_LSB  = 0;
   localparam int IDX_LSB   = SIGN_LSB + Wc;
   localparam int MIN2_LSB  = IDX_LSB + Wcbits;
   localparam int MIN1_LSB  = MIN2_LSB + Wabs;

   typedef enum logic {
      ACC = 1'b0,
      OUT = 1'b1
   } cn_state_t;

   // The most negative input has no positive counterpart, so it clamps to all-ones.
   function automatic logic [Wabs-1:0] sat_abs(input logic [W-1:0] x);
      logic [W-1:0] neg;
      neg = ~x + 1'b1;
      if (!x[W-1])
         return x[Wabs-1:0];
      else if (neg[W-1])
         return {Wabs{1'b1}};
      else
         return neg[Wabs-1:0];
   endfunction

endpackage

// File: rtl/cn_min2_track.sv
// Single-beat min-sum update: saturated magnitude of one edge message and the
// resulting min1/min2/idx next values. Purely combinational.
module cn_min2_track
   import cn_pkg::*;
(
   input  logic [W-1:0]      msg,
   input  logic [Wcbits-1:0] cnt,
   input  logic [Wabs-1:0]   min1,
   input  logic [Wabs-1:0]   min2,
   input  logic [Wcbits-1:0] idx,
   output logic [Wabs-1:0]   min1_next,
   output logic [Wabs-1:0]   min2_next,
   output logic [Wcbits-1:0] idx_next,
   output logic              sign
);

   logic [Wabs-1:0] mag;

   always_comb begin
      mag       = sat_abs(msg);
      sign      = msg[W-1];
      min1_next = min1;
      min2_next = min2;
      idx_next  = idx;
      // Strict compares keep the earliest index on ties.
      if (mag < min1) begin
         min2_next = min1;
         min1_next = mag;
         idx_next  = cnt;
      end else if (mag < min2) begin
         min2_next = mag;
      end
   end

endmodule

// File: rtl/cn_msg_compress.sv
// Check-node message compressor: folds Wc edge messages into one compressed
// word {min1, min2, idx, sign} and holds it until the consumer accepts.
module cn_msg_compress
   import cn_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         in_msg,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ECOMPSIZE-1:0] out_ecomp,
   output logic                 err
);

   cn_state_t            state_reg;
   logic [Wcbits-1:0]    cnt_reg;
   logic [Wabs-1:0]      min1_reg;
   logic [Wabs-1:0]      min2_reg;
   logic [Wcbits-1:0]    idx_reg;
   logic [Wc-1:0]        sign_reg;
   logic [ECOMPSIZE-1:0] out_ecomp_reg;
   logic                 out_valid_reg;
   logic                 in_ready_reg;
   logic                 err_reg;

   logic [Wabs-1:0]      min1_next;
   logic [Wabs-1:0]      min2_next;
   logic [Wcbits-1:0]    idx_next;
   logic                 sign_bit;
   logic [Wc-1:0]        sign_next;
   logic                 accept;
   logic                 last_beat;

   cn_min2_track u_track (
      .msg       (in_msg),
      .cnt       (cnt_reg),
      .min1      (min1_reg),
      .min2      (min2_reg),
      .idx       (idx_reg),
      .min1_next (min1_next),
      .min2_next (min2_next),
      .idx_next  (idx_next),
      .sign      (sign_bit)
   );

   // in_ready_reg is only ever set while in ACC.
   assign accept    = in_valid && in_ready_reg;
   assign last_beat = (cnt_reg == Wcbits'(Wc - 1));

   genvar gi;
   generate
      for (gi = 0; gi < Wc; gi++) begin : g_sign
         assign sign_next[gi] = (cnt_reg == Wcbits'(gi)) ? sign_bit : sign_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ACC;
         cnt_reg       <= '0;
         min1_reg      <= {Wabs{1'b1}};
         min2_reg      <= {Wabs{1'b1}};
         idx_reg       <= '0;
         sign_reg      <= '0;
         out_ecomp_reg <= '0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         case (state_reg)
            ACC: begin
               in_ready_reg <= 1'b1;
               if (accept) begin
                  cnt_reg  <= cnt_reg + 1'b1;
                  min1_reg <= min1_next;
                  min2_reg <= min2_next;
                  idx_reg  <= idx_next;
                  sign_reg <= sign_next;
                  // in_last is a framing check only; the row always closes on cnt.
                  if (in_last != last_beat)
                     err_reg <= 1'b1;
                  if (last_beat) begin
                     out_ecomp_reg <= {min1_next, min2_next, idx_next, sign_next};
                     out_valid_reg <= 1'b1;
                     in_ready_reg  <= 1'b0;
                     state_reg     <= OUT;
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  state_reg     <= ACC;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  cnt_reg       <= '0;
                  min1_reg      <= {Wabs{1'b1}};
                  min2_reg      <= {Wabs{1'b1}};
                  idx_reg       <= '0;
                  sign_reg      <= '0;
               end
            end
            default: state_reg <= ACC;
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_ecomp = out_ecomp_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_cn_msg_compress.sv
// Self-checking bench for cn_msg_compress: rows are driven beat by beat, a
// reference word per complete row is queued and compared at the output.
module tb_cn_msg_compress;
   import cn_pkg::*;

   logic                 clk;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [W-1:0]         in_msg;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [ECOMPSIZE-1:0] out_ecomp;
   logic                 err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0]         row_msg [Wc];
   logic [ECOMPSIZE-1:0] exp_q [$];

   cn_msg_compress dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_msg    (in_msg),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ecomp (out_ecomp),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: min1 is the earliest smallest magnitude, min2 the smallest of all others.
   function automatic logic [ECOMPSIZE-1:0] model_word();
      int m [Wc];
      int v;
      int b1 = 0;
      int m2 = (1 << Wabs) - 1;
      logic [Wc-1:0] s;
      for (int i = 0; i < Wc; i++) begin
         v = $signed(row_msg[i]);
         m[i] = (v < 0) ? -v : v;
         if (m[i] > (1 << Wabs) - 1) m[i] = (1 << Wabs) - 1;
         s[i] = row_msg[i][W-1];
      end
      for (int i = 0; i < Wc; i++)
         if (m[i] < m[b1]) b1 = i;
      for (int i = 0; i < Wc; i++)
         if (i != b1 && m[i] < m2) m2 = m[i];
      return {Wabs'(m[b1]), Wabs'(m2), Wcbits'(b1), s};
   endfunction

   task automatic push_row();
      exp_q.push_back(model_word());
   endtask

   task automatic fill_random();
      for (int i = 0; i < Wc; i++) row_msg[i] = W'($urandom);
   endtask

   // Called and returns at a negedge; drives beats first..last of row_msg.
   task automatic send_beats(input int first, input int last, input int last_beat, input bit gaps);
      int t;
      for (int i = first; i <= last; i++) begin
         if (gaps && (i % 5 == 2)) begin
            in_valid = 1'b0;
            repeat (2) @(negedge clk);
         end
         in_valid = 1'b1;
         in_msg   = row_msg[i];
         in_last  = (i == last_beat);
         t = 0;
         while (!in_ready && t < 64) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout beat=%0d in_ready=%b expected 1", i, in_ready);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
         end
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Wait for a word, compare with the scoreboard head, then hand it off.
   task automatic pop_check(input string name);
      int t = 0;
      logic [ECOMPSIZE-1:0] exp;
      while (!out_valid && t < 64) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (!out_valid) begin
         n_fail++;
         $display("FAIL %s out_valid_timeout got=%b expected 1", name, out_valid);
         return;
      end
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s unexpected_output got=%h expected none", name, out_ecomp);
         return;
      end
      exp = exp_q.pop_front();
      if (out_ecomp !== exp) begin
         n_fail++;
         $display("FAIL %s ecomp got=%h expected %h", name, out_ecomp, exp);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s in_ready_during_out got=%b expected 0", name, in_ready);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s after_accept out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
      end
      $display("row %s: ecomp=%h min1=%0d min2=%0d idx=%0d sign=%h", name, exp,
               exp[MIN1_LSB +: Wabs], exp[MIN2_LSB +: Wabs], exp[IDX_LSB +: Wcbits], exp[SIGN_LSB +: Wc]);
   endtask

   task automatic check_fields(input string name, input int min1, input int min2,
                               input int idx, input logic [Wc-1:0] sign);
      n_checks++;
      if (out_ecomp[MIN1_LSB +: Wabs] !== Wabs'(min1) || out_ecomp[MIN2_LSB +: Wabs] !== Wabs'(min2) ||
          out_ecomp[IDX_LSB +: Wcbits] !== Wcbits'(idx) || out_ecomp[SIGN_LSB +: Wc] !== sign) begin
         n_fail++;
         $display("FAIL %s fields got=%0d/%0d/%0d/%h expected %0d/%0d/%0d/%h", name,
                  out_ecomp[MIN1_LSB +: Wabs], out_ecomp[MIN2_LSB +: Wabs],
                  out_ecomp[IDX_LSB +: Wcbits], out_ecomp[SIGN_LSB +: Wc], min1, min2, idx, sign);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_ecomp !== '0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s reset_outputs got in_ready=%b out_valid=%b ecomp=%h err=%b expected all 0",
                  name, in_ready, out_valid, out_ecomp, err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release in_ready got=%b expected 1", in_ready);
      end
      $display("reset: done");
   endtask

   task automatic test_descending();
      for (int i = 0; i < Wc; i++) row_msg[i] = W'(100 - i);
      push_row();
      send_beats(0, Wc - 1, Wc - 1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL descending latency out_valid=%b err=%b expected 1/0", out_valid, err);
      end
      check_fields("descending", 69, 70, 31, 32'h0);
      pop_check("descending");
   endtask

   task automatic test_two_minima();
      for (int i = 0; i < Wc; i++) row_msg[i] = W'(5);
      row_msg[7]  = W'(-3);
      row_msg[20] = W'(-4);
      push_row();
      send_beats(0, Wc - 1, Wc - 1, 1'b1);
      check_fields("two_minima", 3, 4, 7, 32'h0010_0080);
      pop_check("two_minima");
   endtask

   task automatic test_saturation();
      for (int i = 0; i < Wc; i++) row_msg[i] = W'(511);
      row_msg[0] = W'(-512);
      push_row();
      send_beats(0, Wc - 1, Wc - 1, 1'b0);
      check_fields("saturation", 511, 511, 0, 32'h1);
      pop_check("saturation");
   endtask

   task automatic test_back_to_back();
      int t = 0;
      fill_random();
      push_row();
      send_beats(0, Wc - 1, Wc - 1, 1'b0);
      while (!out_valid && t < 64) begin
         @(negedge clk);
         t++;
      end
      // Hold the output and offer garbage input that must be ignored.
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_msg   = W'($urandom);
         @(negedge clk);
         n_checks++;
         if (exp_q.size() == 0 || out_ecomp !== exp_q[0] || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure cycle=%0d ecomp=%h in_ready=%b out_valid=%b expected stable/0/1",
                     c, out_ecomp, in_ready, out_valid);
         end
      end
      in_valid = 1'b0;
      pop_check("backpressure");
      fill_random();
      push_row();
      send_beats(0, Wc - 1, Wc - 1, 1'b0);
      pop_check("back_to_back");
   endtask

   task automatic test_framing_err();
      fill_random();
      push_row();
      send_beats(0, 14, 15, 1'b0);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL framing_before err got=%b expected 0", err);
      end
      send_beats(15, 15, 15, 1'b0);
      n_checks++;
      if (err !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL framing_set err=%b out_valid=%b expected 1/0", err, out_valid);
      end
      send_beats(16, Wc - 1, 15, 1'b0);
      pop_check("framing_row");
      fill_random();
      push_row();
      send_beats(0, Wc - 1, Wc - 1, 1'b0);
      pop_check("framing_good_row");
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL framing_sticky err got=%b expected 1", err);
      end
   endtask

   task automatic test_reset_mid_row();
      fill_random();
      send_beats(0, 12, Wc - 1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset_mid_row");
      rst = 1'b0;
      @(negedge clk);
      fill_random();
      push_row();
      send_beats(0, Wc - 1, Wc - 1, 1'b0);
      pop_check("after_reset");
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset err got=%b expected 0", err);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_msg    = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_descending();
      test_two_minima();
      test_saturation();
      test_back_to_back();
      test_framing_err();
      test_reset_mid_row();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover got=%0d expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
